// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle instruction sequencer for the 8-bit processor. It steps through
//   FETCH/DECODE/EXEC/WB/BRANCH, handshakes with instruction memory, issues
//   registered datapath controls derived from the 2-bit opcode, counts retired
//   instructions and flags instruction-fetch timeouts.
//
//   Optional feature macro: SEQ_SINGLE_STEP_EN
//     defined   -> adds the step port and a PAUSE state after every retire
//     undefined -> no step port; the instruction boundary goes straight to FETCH
//
// Parameters
//   CNT_W          width of the retired-instruction counter
//   FETCH_TIMEOUT  FETCH cycles without ack before fetch_err (0 = never)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   leave IDLE and begin fetching
//   halt_req   in   stop at the next instruction boundary
//   imem_ack   in   instruction memory has a valid instruction (FETCH only)
//   opcode     in   [1:0] IR opcode, valid from DECODE onward
//   zero_flag  in   datapath zero flag, sampled in EXEC
//   step       in   advance one instruction (SEQ_SINGLE_STEP_EN only)
//   imem_req   out  fetch request, high throughout FETCH
//   ir_load    out  one-cycle IR capture pulse
//   pc_en      out  one-cycle PC update pulse
//   pc_sel     out  0 = PC+1, 1 = branch target (valid with pc_en)
//   mux_a, mux_b, sign_ex, alu_ctrl  out  registered datapath controls
//   reg_write  out  one-cycle register-file write pulse
//   busy       out  high in every state except IDLE
//   fetch_err  out  sticky fetch-timeout flag, cleared by reset or start
//   retired    out  [CNT_W-1:0] retired-instruction count (wraps)
//
//   Every output comes straight from a flop; strobes are computed from the
//   next state so that they line up with the state they describe.

module cpu_sequencer #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             imem_ack,
    input  logic [1:0]       opcode,
    input  logic             zero_flag,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             mux_a,
    output logic             mux_b,
    output logic             sign_ex,
    output logic             alu_ctrl,
    output logic             reg_write,
    output logic             busy,
    output logic             fetch_err,
    output logic [CNT_W-1:0] retired
);

    // Wait counter holds 0 .. FETCH_TIMEOUT-1 while in FETCH.
    localparam int unsigned WAIT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
    localparam logic [WAIT_W-1:0] TO_LAST =
        WAIT_W'((FETCH_TIMEOUT == 0) ? 32'd0 : FETCH_TIMEOUT - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_BRANCH
`ifdef SEQ_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_timeout;
    logic [WAIT_W-1:0]  r_wait;

    logic               r_imem_req;
    logic               r_ir_load;
    logic               r_pc_en;
    logic               r_pc_sel;
    logic               r_mux_a;
    logic               r_mux_b;
    logic               r_sign_ex;
    logic               r_alu_ctrl;
    logic               r_reg_write;
    logic               r_busy;
    logic               r_fetch_err;
    logic [CNT_W-1:0]   r_retired;

    // Timeout fires on the FETCH_TIMEOUT-th FETCH cycle that has no ack.
    always_comb begin
        w_timeout = 1'b0;
        if (FETCH_TIMEOUT != 0 && r_state == S_FETCH && !imem_ack && r_wait == TO_LAST)
            w_timeout = 1'b1;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH: begin
                if (imem_ack)       w_next = S_DECODE;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = opcode[1] ? S_BRANCH : S_WB;
            S_WB, S_BRANCH: begin
                if (halt_req) w_next = S_IDLE;
`ifdef SEQ_SINGLE_STEP_EN
                else          w_next = S_PAUSE;
`else
                else          w_next = S_FETCH;
`endif
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (halt_req)  w_next = S_IDLE;
                else if (step) w_next = S_FETCH;
            end
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_imem_req  <= 1'b0;
            r_ir_load   <= 1'b0;
            r_pc_en     <= 1'b0;
            r_pc_sel    <= 1'b0;
            r_mux_a     <= 1'b0;
            r_mux_b     <= 1'b0;
            r_sign_ex   <= 1'b0;
            r_alu_ctrl  <= 1'b0;
            r_reg_write <= 1'b0;
            r_busy      <= 1'b0;
            r_fetch_err <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == S_FETCH) r_wait <= r_wait + WAIT_W'(1);
            else                    r_wait <= '0;

            r_imem_req  <= (w_next == S_FETCH);
            r_ir_load   <= (r_state == S_FETCH) && imem_ack;
            r_reg_write <= (w_next == S_WB);
            r_pc_en     <= (w_next == S_WB) || (w_next == S_BRANCH);
            // Branch decision is taken at the EXEC->BRANCH edge; 10 always
            // jumps, 11 jumps only on zero.
            r_pc_sel    <= (r_state == S_EXEC) && opcode[1] && (!opcode[0] || zero_flag);
            r_busy      <= (w_next != S_IDLE);

            if (w_timeout)
                r_fetch_err <= 1'b1;
            else if (r_state == S_IDLE && start)
                r_fetch_err <= 1'b0;

            if (r_state == S_DECODE) begin
                r_mux_a    <= opcode[1];
                r_sign_ex  <= opcode[1];
                r_mux_b    <= opcode[0];
                r_alu_ctrl <= opcode[0];
            end else if (w_next == S_IDLE) begin
                r_mux_a    <= 1'b0;
                r_sign_ex  <= 1'b0;
                r_mux_b    <= 1'b0;
                r_alu_ctrl <= 1'b0;
            end

            // EXEC always retires into WB or BRANCH, so the count becomes
            // visible together with the pc_en pulse.
            if (r_state == S_EXEC)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign imem_req  = r_imem_req;
    assign ir_load   = r_ir_load;
    assign pc_en     = r_pc_en;
    assign pc_sel    = r_pc_sel;
    assign mux_a     = r_mux_a;
    assign mux_b     = r_mux_b;
    assign sign_ex   = r_sign_ex;
    assign alu_ctrl  = r_alu_ctrl;
    assign reg_write = r_reg_write;
    assign busy      = r_busy;
    assign fetch_err = r_fetch_err;
    assign retired   = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n, start, halt_req, imem_ack, zero_flag;
    logic [1:0] opcode;
`ifdef SEQ_SINGLE_STEP_EN
    logic step;
`endif
    logic imem_req, ir_load, pc_en, pc_sel, mux_a, mux_b, sign_ex, alu_ctrl;
    logic reg_write, busy, fetch_err;
    logic [CNT_W-1:0] retired;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       sel;
        logic       wr;
        logic [15:0] cnt;
    } retire_t;
    retire_t sb[$];
    logic [15:0] exp_ret = '0;

    always #5 clk = ~clk;

    cpu_sequencer #(.CNT_W(CNT_W), .FETCH_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .imem_ack(imem_ack), .opcode(opcode), .zero_flag(zero_flag),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .imem_req(imem_req), .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel),
        .mux_a(mux_a), .mux_b(mux_b), .sign_ex(sign_ex), .alu_ctrl(alu_ctrl),
        .reg_write(reg_write), .busy(busy), .fetch_err(fetch_err), .retired(retired)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected retire: push when the instruction's opcode is presented.
    task automatic expect_retire(input logic sel, input logic wr);
        retire_t e;
        exp_ret = exp_ret + 16'd1;
        e.sel = sel;
        e.wr  = wr;
        e.cnt = exp_ret;
        sb.push_back(e);
    endtask

    // Retire monitor: every pc_en pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && pc_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pc_en", 32'(pc_en), 32'd0);
            end else begin
                retire_t e;
                e = sb.pop_front();
                check("retire_pc_sel", 32'(pc_sel), 32'(e.sel));
                check("retire_reg_write", 32'(reg_write), 32'(e.wr));
                check("retire_count", 32'(retired), 32'(e.cnt));
            end
        end else if (rst_n === 1'b1) begin
            check("reg_write_without_pc_en", 32'(reg_write), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
        opcode = 2'b00; zero_flag = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_strobes", {28'd0, ir_load, pc_en, pc_sel, reg_write}, 0);
        check("rst_ctrls", {28'd0, mux_a, mux_b, sign_ex, alu_ctrl}, 0);
        check("rst_fetch_err", 32'(fetch_err), 0);
        check("rst_retired", 32'(retired), 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 0);

        // opcode 01, ack on first FETCH cycle, halt at the boundary
        start = 1'b1; tick();
        check("t1_fetch_req", 32'(imem_req), 1);
        check("t1_busy", 32'(busy), 1);
        start = 1'b0; imem_ack = 1'b1; opcode = 2'b01;
        expect_retire(1'b0, 1'b1);
        tick();
        check("t1_ir_load", 32'(ir_load), 1);
        check("t1_req_drop", 32'(imem_req), 0);
        imem_ack = 1'b0; halt_req = 1'b1;
        tick();
        check("t1_ctrls", {28'd0, mux_a, mux_b, sign_ex, alu_ctrl}, 32'b0101);
        check("t1_ir_load_once", 32'(ir_load), 0);
        tick();
        check("t1_wb_write", 32'(reg_write), 1);
        check("t1_retired", 32'(retired), 1);
        tick();
        check("t1_idle", 32'(busy), 0);
        check("t1_ctrls_clr", {28'd0, mux_a, mux_b, sign_ex, alu_ctrl}, 0);
        halt_req = 1'b0;

        // two opcode-11 branches: zero=1 taken, zero=0 not taken
        start = 1'b1; tick();
        start = 1'b0; imem_ack = 1'b1; opcode = 2'b11; zero_flag = 1'b1;
        expect_retire(1'b1, 1'b0);
        tick(); imem_ack = 1'b0;
        tick();
        check("t2_ctrls", {28'd0, mux_a, mux_b, sign_ex, alu_ctrl}, 32'b1111);
        tick();
        check("t2_taken", 32'(pc_sel), 1);
        tick();
`ifdef SEQ_SINGLE_STEP_EN
        check("t2_pause_busy", 32'(busy), 1);
        check("t2_pause_req", 32'(imem_req), 0);
        tick();
        check("t2_pause_hold", 32'(imem_req), 0);
        step = 1'b1; tick(); step = 1'b0;
`endif
        check("t2_back_to_fetch", 32'(imem_req), 1);
        imem_ack = 1'b1; opcode = 2'b11; zero_flag = 1'b0;
        expect_retire(1'b0, 1'b0);
        tick(); imem_ack = 1'b0; halt_req = 1'b1;
        tick(); tick();
        check("t2_not_taken", 32'(pc_sel), 0);
        tick();
        check("t2_idle", 32'(busy), 0);
        check("t2_retired", 32'(retired), 3);
        halt_req = 1'b0;

        // ack withheld for 3 cycles, then opcode 00 with halt over EXEC/WB
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t3_req_held", 32'(imem_req), 1);
            check("t3_no_ir_load", 32'(ir_load), 0);
            if (i == 3) begin
                imem_ack = 1'b1; opcode = 2'b00;
                expect_retire(1'b0, 1'b1);
            end
            tick();
        end
        check("t3_ir_load", 32'(ir_load), 1);
        check("t3_req_drop", 32'(imem_req), 0);
        check("t3_no_err", 32'(fetch_err), 0);
        imem_ack = 1'b0;
        tick();
        check("t3_ir_load_once", 32'(ir_load), 0);
        halt_req = 1'b1;
        tick();
        check("t3_wb_write", 32'(reg_write), 1);
        tick();
        check("t3_halt_idle", 32'(busy), 0);
        halt_req = 1'b0;

        // fetch timeout after 15 cycles, cleared by start
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("t4_fetching", {30'd0, imem_req, fetch_err}, 32'b10);
            tick();
        end
        check("t4_err", 32'(fetch_err), 1);
        check("t4_idle", {30'd0, busy, imem_req}, 0);
        tick();
        check("t4_err_sticky", 32'(fetch_err), 1);
        start = 1'b1; tick(); start = 1'b0;
        check("t4_err_clr", 32'(fetch_err), 0);

        // reset during DECODE
        imem_ack = 1'b1; opcode = 2'b01;
        tick(); imem_ack = 1'b0;
        rst_n = 1'b0; tick();
        exp_ret = '0;
        check("t5_rst_outs", {20'd0, imem_req, ir_load, pc_en, pc_sel, mux_a, mux_b,
                              sign_ex, alu_ctrl, reg_write, busy, fetch_err, 1'b0}, 0);
        check("t5_rst_retired", 32'(retired), 0);
        rst_n = 1'b1; tick(); tick();
        check("t5_stays_idle", 32'(busy), 0);

        // ack in IDLE ignored; start+halt together: start wins, halt at boundary
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        check("t6_ack_idle", {30'd0, ir_load, busy}, 0);
        start = 1'b1; halt_req = 1'b1; tick(); start = 1'b0;
        check("t6_start_wins", 32'(busy), 1);
        imem_ack = 1'b1; opcode = 2'b10; zero_flag = 1'b0;
        expect_retire(1'b1, 1'b0);
        tick(); imem_ack = 1'b0;
        tick(); tick();
        check("t6_jump", 32'(pc_sel), 1);
        tick();
        check("t6_halt_idle", 32'(busy), 0);
        halt_req = 1'b0;

`ifdef SEQ_SINGLE_STEP_EN
        // step and halt together in PAUSE: halt wins
        start = 1'b1; tick(); start = 1'b0;
        imem_ack = 1'b1; opcode = 2'b01;
        expect_retire(1'b0, 1'b1);
        tick(); imem_ack = 1'b0;
        tick(); tick(); tick();
        check("t7_paused", {30'd0, busy, imem_req}, 32'b10);
        step = 1'b1; halt_req = 1'b1; tick();
        step = 1'b0; halt_req = 1'b0;
        check("t7_halt_over_step", {30'd0, busy, imem_req}, 0);
`endif

        tick(); tick();
        check("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
